jtag_tap_controller: RTL and testbench

//  IEEE 1149.1-style TAP controller driving the ripple-adder boundary-scan chain input stage.

---
 rtl/jtag_pkg.sv | 64 ++++++
 rtl/jtag_tap_fsm.sv | 41 ++++
 rtl/jtag_tap_controller.sv | 127 ++++++++++++
 tb/tb_jtag_tap_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, IR opcodes and DR select decode.
// Optional IDCODE data register is enabled with the JTAG_IDCODE_EN macro.
package jtag_pkg;

  localparam int unsigned IR_W    = 4;
  localparam int unsigned BSR_LEN = 34;

`ifdef JTAG_IDCODE_EN
  localparam int unsigned     ID_W   = 32;
  localparam logic [ID_W-1:0] IDCODE = 32'h1000_0001;
`endif

  localparam logic [IR_W-1:0] OP_EXTEST         = 4'b0000;
  localparam logic [IR_W-1:0] OP_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [IR_W-1:0] OP_IDCODE         = 4'b0010;
  localparam logic [IR_W-1:0] OP_BYPASS         = 4'b1111;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] OP_DEFAULT = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] OP_DEFAULT = OP_BYPASS;
`endif

  // Standard 1149.1 state encoding, so tap_state matches common debug tooling
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_BSR    = 2'd1,
    DR_IDCODE = 2'd2
  } dr_sel_e;

  // Map an instruction to the data register it selects; unknown opcodes act as BYPASS
  function automatic dr_sel_e decode_dr_sel(input logic [IR_W-1:0] op);
    dr_sel_e sel;
    sel = DR_BYPASS;
    case (op)
      OP_EXTEST, OP_SAMPLE_PRELOAD: sel = DR_BSR;
`ifdef JTAG_IDCODE_EN
      OP_IDCODE:                    sel = DR_IDCODE;
`endif
      default:                      sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state machine driven by TMS on the rising test clock.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q;

  // State register with the 1149.1 TMS transition table
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      case (state_q)
        TEST_LOGIC_RESET: state_q <= tms_i ? TEST_LOGIC_RESET : RUN_IDLE;
        RUN_IDLE:         state_q <= tms_i ? SELECT_DR        : RUN_IDLE;
        SELECT_DR:        state_q <= tms_i ? SELECT_IR        : CAPTURE_DR;
        CAPTURE_DR:       state_q <= tms_i ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state_q <= tms_i ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state_q <= tms_i ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state_q <= tms_i ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state_q <= tms_i ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state_q <= tms_i ? SELECT_DR        : RUN_IDLE;
        SELECT_IR:        state_q <= tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_q <= tms_i ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state_q <= tms_i ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state_q <= tms_i ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state_q <= tms_i ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state_q <= tms_i ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state_q <= tms_i ? SELECT_DR        : RUN_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller for the adder boundary-scan chain: IR, BYPASS, optional IDCODE,
// TDO mux and boundary-cell clock/update generation.
// Define JTAG_IDCODE_EN to include the 32-bit IDCODE data register.
module jtag_tap_controller
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       bsc_tdo,
  output logic       TDO,
  output logic       TDO_en,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Mode,
  output logic [3:0] tap_state
);

  tap_state_e        state;
  dr_sel_e           dr_sel;
  logic [IR_W-1:0]   ir_sr_q;
  logic [IR_W-1:0]   ir_q;
  logic              bypass_q;
  logic              mode_q;
  logic              clkdr_q;
  logic              tdo_q;
  logic              tdo_en_q;
  logic              tdo_d;

  jtag_tap_fsm u_fsm (
    .clk_i  (TCK),
    .rst_ni (TRSTn),
    .tms_i  (TMS),
    .state_o(state)
  );

  // Active instruction selects the data register
  always_comb begin
    dr_sel = decode_dr_sel(ir_q);
  end

  // IR shift stage and BYPASS bit, both clocked on rising TCK
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      ir_sr_q  <= IR_W'(1);
      bypass_q <= 1'b0;
    end else begin
      case (state)
        CAPTURE_IR: ir_sr_q <= IR_W'(1);
        SHIFT_IR:   ir_sr_q <= {TDI, ir_sr_q[IR_W-1:1]};
        default:    ;
      endcase
      case (state)
        CAPTURE_DR: bypass_q <= 1'b0;
        SHIFT_DR:   bypass_q <= TDI;
        default:    ;
      endcase
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [ID_W-1:0] idcode_sr_q;

  // IDCODE capture/shift, only while IDCODE is the selected data register
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      idcode_sr_q <= IDCODE;
    end else if (dr_sel == DR_IDCODE) begin
      case (state)
        CAPTURE_DR: idcode_sr_q <= IDCODE;
        SHIFT_DR:   idcode_sr_q <= {TDI, idcode_sr_q[ID_W-1:1]};
        default:    ;
      endcase
    end
  end
`endif

  // Serial output source for the current shift state
  always_comb begin
    tdo_d = 1'b0;
    case (state)
      SHIFT_IR: tdo_d = ir_sr_q[0];
      SHIFT_DR: begin
        case (dr_sel)
          DR_BSR:    tdo_d = bsc_tdo;
`ifdef JTAG_IDCODE_EN
          DR_IDCODE: tdo_d = idcode_sr_q[0];
`endif
          default:   tdo_d = bypass_q;
        endcase
      end
      default:  tdo_d = 1'b0;
    endcase
  end

  // Falling-edge registers: active IR, Mode, TDO, TDO enable and ClockDR gate
  always_ff @(negedge TCK) begin
    if (!TRSTn || state == TEST_LOGIC_RESET) begin
      ir_q     <= OP_DEFAULT;
      mode_q   <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
      clkdr_q  <= 1'b0;
    end else begin
      if (state == UPDATE_IR) begin
        ir_q   <= ir_sr_q;
        mode_q <= (ir_sr_q == OP_EXTEST);
      end
      tdo_q    <= tdo_d;
      tdo_en_q <= (state == SHIFT_IR) || (state == SHIFT_DR);
      // Set while TCK is low so the gated clock only ever rises with TCK
      clkdr_q  <= ((state == CAPTURE_DR) || (state == SHIFT_DR)) && (dr_sel == DR_BSR);
    end
  end

  assign TDO       = tdo_q;
  assign TDO_en    = tdo_en_q;
  assign Mode      = mode_q;
  assign ClockDR   = TCK & clkdr_q;
  // One pulse in the low half of the UPDATE_DR cycle
  assign UpdateDR  = ~TCK & (state == UPDATE_DR) & (dr_sel == DR_BSR);
  assign ShiftDR   = (state == SHIFT_DR) && (dr_sel == DR_BSR);
  assign tap_state = 4'(state);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller; follows JTAG_IDCODE_EN if defined.
module tb_jtag_tap_controller;
  import jtag_pkg::*;

  logic       TCK;
  logic       TRSTn;
  logic       TMS;
  logic       TDI;
  logic       bsc_tdo;
  logic       TDO;
  logic       TDO_en;
  logic       ShiftDR;
  logic       ClockDR;
  logic       UpdateDR;
  logic       Mode;
  logic [3:0] tap_state;

  jtag_tap_controller dut (
    .TCK      (TCK),
    .TRSTn    (TRSTn),
    .TMS      (TMS),
    .TDI      (TDI),
    .bsc_tdo  (bsc_tdo),
    .TDO      (TDO),
    .TDO_en   (TDO_en),
    .ShiftDR  (ShiftDR),
    .ClockDR  (ClockDR),
    .UpdateDR (UpdateDR),
    .Mode     (Mode),
    .tap_state(tap_state)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int   n_vec = 0;
  int   n_err = 0;
  int   clk_total = 0;
  int   clk_shift = 0;
  int   upd_total = 0;
  logic count_en = 1'b0;

  always @(posedge ClockDR) begin
    clk_total++;
    if (count_en) clk_shift++;
  end

  always @(posedge UpdateDR) upd_total++;

  // TMS paths from TEST_LOGIC_RESET to each state, LSB applied first
  localparam logic [7:0] PATH_BITS [16] = '{
    8'b0000_0000, 8'b0000_0000, 8'b0000_0010, 8'b0000_0010,
    8'b0000_0010, 8'b0000_1010, 8'b0000_1010, 8'b0010_1010,
    8'b0001_1010, 8'b0000_0110, 8'b0000_0110, 8'b0000_0110,
    8'b0001_0110, 8'b0001_0110, 8'b0101_0110, 8'b0011_0110};
  localparam int PATH_LEN [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  localparam tap_state_e PATH_ST [16] = '{
    TEST_LOGIC_RESET, RUN_IDLE, SELECT_DR, CAPTURE_DR,
    SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR,
    UPDATE_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR,
    EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR};

  logic [7:0]  pbits;
  logic [7:0]  pat;
  logic [31:0] word;
  int          base_upd;
  int          base_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK: drive inputs in the low phase, sample just after the next falling edge
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic do_reset();
    TRSTn = 1'b0;
    step(1'b0, 1'b0);
    TRSTn = 1'b1;
  endtask

  // From RUN_IDLE: load an opcode LSB first, update, return to RUN_IDLE
  task automatic load_ir(input logic [IR_W-1:0] op);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("ir_capture_lsb", 32'(TDO), 32'd1);
    check("ir_tdo_en", 32'(TDO_en), 32'd1);
    for (int i = 0; i < int'(IR_W); i++) step(i == int'(IR_W) - 1, op[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RUN_IDLE into SHIFT_DR (capture already done)
  task automatic dr_enter();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    TRSTn   = 1'b1;
    TMS     = 1'b1;
    TDI     = 1'b0;
    bsc_tdo = 1'b0;
    @(negedge TCK);

    // Reset state
    do_reset();
    check("rst_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
    check("rst_mode", 32'(Mode), 32'd0);
    check("rst_shiftdr", 32'(ShiftDR), 32'd0);
    check("rst_tdo_en", 32'(TDO_en), 32'd0);

    // Reach every state, then five TMS=1 clocks must return to TEST_LOGIC_RESET
    for (int s = 0; s < 16; s++) begin
      do_reset();
      pbits = PATH_BITS[s];
      for (int j = 0; j < PATH_LEN[s]; j++) step(pbits[j], 1'b0);
      check($sformatf("reach_%0d", s), 32'(tap_state), 32'(PATH_ST[s]));
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      check($sformatf("tms5_from_%0d", s), 32'(tap_state), 32'(TEST_LOGIC_RESET));
    end

    do_reset();
    step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
    // Default instruction is IDCODE: shift out the device ID
    base_upd = upd_total;
    dr_enter();
    word = 32'h0;
    word[0] = TDO;
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b0);
      word[i] = TDO;
    end
    check("idcode_value", word, 32'h1000_0001);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("idcode_no_update", 32'(upd_total - base_upd), 32'd0);
`else
    // Without IDCODE, opcode 0010 behaves as BYPASS
    load_ir(OP_IDCODE);
    check("id_as_bypass_mode", 32'(Mode), 32'd0);
    dr_enter();
    check("id_as_bypass_cap", 32'(TDO), 32'd0);
    step(1'b0, 1'b1);
    check("id_as_bypass_b0", 32'(TDO), 32'd1);
    step(1'b0, 1'b0);
    check("id_as_bypass_b1", 32'(TDO), 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`endif

    // EXTEST: Mode, ShiftDR, 34 shift edges on ClockDR, one UpdateDR pulse
    load_ir(OP_EXTEST);
    check("extest_mode", 32'(Mode), 32'd1);
    base_upd = upd_total;
    base_clk = clk_total;
    dr_enter();
    check("extest_shiftdr", 32'(ShiftDR), 32'd1);
    count_en = 1'b1;
    for (int i = 0; i < int'(BSR_LEN); i++) begin
      bsc_tdo = i[0];
      step(i == int'(BSR_LEN) - 1, 1'(i % 3 == 0));
      if (i == 2) check("extest_tdo_b2", 32'(TDO), 32'd0);
      if (i == 3) check("extest_tdo_b3", 32'(TDO), 32'd1);
    end
    count_en = 1'b0;
    check("extest_exit1", 32'(tap_state), 32'(EXIT1_DR));
    check("extest_clkdr_shift", 32'(clk_shift), 32'd34);
    // one capture edge plus 34 shift edges
    check("extest_clkdr_total", 32'(clk_total - base_clk), 32'd35);
    step(1'b1, 1'b0);
    check("extest_updatedr_level", 32'(UpdateDR), 32'd1);
    step(1'b0, 1'b0);
    check("extest_updatedr_cnt", 32'(upd_total - base_upd), 32'd1);

    // BYPASS: captured 0, then A5 with one TCK of delay, no UpdateDR
    load_ir(OP_BYPASS);
    check("bypass_mode", 32'(Mode), 32'd0);
    base_upd = upd_total;
    dr_enter();
    check("bypass_capture", 32'(TDO), 32'd0);
    check("bypass_shiftdr", 32'(ShiftDR), 32'd0);
    pat  = 8'hA5;
    word = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, pat[i]);
      word[i] = TDO;
    end
    check("bypass_a5", word, 32'h0000_00A5);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("bypass_no_update", 32'(upd_total - base_upd), 32'd0);

    // Reset in the middle of an EXTEST DR shift
    load_ir(OP_EXTEST);
    check("abort_mode_pre", 32'(Mode), 32'd1);
    base_upd = upd_total;
    dr_enter();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    TRSTn = 1'b0;
    step(1'b0, 1'b0);
    TRSTn = 1'b1;
    check("abort_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
    check("abort_mode", 32'(Mode), 32'd0);
    check("abort_tdo_en", 32'(TDO_en), 32'd0);
    check("abort_no_update", 32'(upd_total - base_upd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
